// File: rtl/stopwatch_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_counter_if
// Description : Control pulses and display outputs of the stopwatch core.
// Revision    : 1.0 - initial release
// ============================================================================
interface stopwatch_counter_if;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] dig_min;
    logic [3:0] dig_sec10;
    logic [3:0] dig_sec1;
    logic [3:0] dig_tenth;
    logic       running;
    logic       frozen;
    logic       wrap;

    modport master (
        output start_stop, clear, lap,
        input  dig_min, dig_sec10, dig_sec1, dig_tenth, running, frozen, wrap
    );

    modport slave (
        input  start_stop, clear, lap,
        output dig_min, dig_sec10, dig_sec1, dig_tenth, running, frozen, wrap
    );
endinterface
`default_nettype wire

// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_counter
// Description : 0.1 s prescaler and M:SS.t BCD counter with start/stop, clear
//               and lap freeze. Lap freeze built only with STOPWATCH_LAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_counter #(
    parameter int DIV = 5000000,
    parameter int CW  = 23
) (
    input  wire logic         clk,
    input  wire logic         rst,
    stopwatch_counter_if.slave sw
);

    typedef enum logic [0:0] {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    localparam logic [CW-1:0] C_TICK_AT = CW'(DIV - 1);
    localparam logic [CW-1:0] C_ONE     = CW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_presc;
    logic [3:0]    r_min;
    logic [3:0]    r_sec10;
    logic [3:0]    r_sec1;
    logic [3:0]    r_tenth;
    logic          r_wrap;

    logic          w_tick;
    logic          w_c_tenth;
    logic          w_c_sec1;
    logic          w_c_sec10;
    logic          w_c_min;
    logic [15:0]   w_live;
    logic [15:0]   w_disp;
    logic          w_frozen;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_STOPPED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (sw.clear) begin
            w_state_nxt = ST_STOPPED;
        end else if (sw.start_stop) begin
            w_state_nxt = (r_state == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
        end
    end

    assign w_tick    = (r_state == ST_RUNNING) && (r_presc == C_TICK_AT);
    assign w_c_tenth = (r_tenth == 4'd9);
    assign w_c_sec1  = w_c_tenth && (r_sec1 == 4'd9);
    assign w_c_sec10 = w_c_sec1 && (r_sec10 == 4'd5);
    assign w_c_min   = w_c_sec10 && (r_min == 4'd9);

    // A tick on the stopping edge still counts; the prescaler simply holds while stopped.
    always_ff @(posedge clk) begin
        if (rst || sw.clear) begin
            r_presc <= '0;
            r_min   <= 4'd0;
            r_sec10 <= 4'd0;
            r_sec1  <= 4'd0;
            r_tenth <= 4'd0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= w_tick && w_c_min;
            if (w_tick) begin
                r_presc <= '0;
                r_tenth <= w_c_tenth ? 4'd0 : r_tenth + 4'd1;
                if (w_c_tenth) begin
                    r_sec1 <= w_c_sec1 ? 4'd0 : r_sec1 + 4'd1;
                end
                if (w_c_sec1) begin
                    r_sec10 <= w_c_sec10 ? 4'd0 : r_sec10 + 4'd1;
                end
                if (w_c_sec10) begin
                    r_min <= w_c_min ? 4'd0 : r_min + 4'd1;
                end
            end else if (r_state == ST_RUNNING) begin
                r_presc <= r_presc + C_ONE;
            end
        end
    end

    assign w_live = {r_min, r_sec10, r_sec1, r_tenth};

`ifdef STOPWATCH_LAP_EN
    logic        r_frozen;
    logic [15:0] r_lap;

    // Capture uses the pre-edge count, so a coincident tick is not included.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frozen <= 1'b0;
            r_lap    <= 16'd0;
        end else if (sw.clear) begin
            r_frozen <= 1'b0;
        end else if (sw.lap) begin
            if (r_frozen) begin
                r_frozen <= 1'b0;
            end else if (r_state == ST_RUNNING) begin
                r_lap    <= w_live;
                r_frozen <= 1'b1;
            end
        end
    end

    assign w_frozen = r_frozen;
    assign w_disp   = r_frozen ? r_lap : w_live;
`else
    assign w_frozen = 1'b0;
    assign w_disp   = w_live;
`endif

    assign {sw.dig_min, sw.dig_sec10, sw.dig_sec1, sw.dig_tenth} = w_disp;
    assign sw.running = (r_state == ST_RUNNING);
    assign sw.frozen  = w_frozen;
    assign sw.wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_counter
// Description : Self-checking bench for stopwatch_counter (DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_counter;

    localparam int DIV = 4;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stopwatch_counter_if sw_if();

    stopwatch_counter #(.DIV(DIV), .CW(3)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: elapsed time as an integer number of tenths.
    int m_t;
    int m_phase;
    int m_lap;
    bit m_run;
    bit m_frz;
    bit m_wrap;

    typedef struct {
        bit ss;
        bit cl;
        bit lp;
        int idle;
        int exp_t;
        bit exp_run;
        bit exp_frz;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [15:0] to_bcd(int t);
        int sec;
        sec = (t / 10) % 60;
        return {4'(t / 600), 4'(sec / 10), 4'(sec % 10), 4'(t % 10)};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {13'd0, sw_if.dig_min, sw_if.dig_sec10, sw_if.dig_sec1, sw_if.dig_tenth,
                sw_if.running, sw_if.frozen, sw_if.wrap};
    endfunction

    function automatic logic [31:0] model_vec();
        return {13'd0, to_bcd(m_frz ? m_lap : m_t), m_run, m_frz, m_wrap};
    endfunction

    function automatic logic [31:0] const_vec(int t, bit run, bit frz, bit wr);
        return {13'd0, to_bcd(t), run, frz, wr};
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic model_reset();
        m_t = 0; m_phase = 0; m_lap = 0; m_run = 0; m_frz = 0; m_wrap = 0;
    endtask

    task automatic model_step(bit ss, bit cl, bit lp);
        bit tick;
        tick   = m_run && (m_phase == DIV - 1);
        m_wrap = 1'b0;
        if (cl) begin
            m_t = 0; m_phase = 0; m_run = 0; m_frz = 0;
        end else begin
            if (LAP_EN && lp) begin
                if (m_frz) m_frz = 0;
                else if (m_run) begin m_lap = m_t; m_frz = 1; end
            end
            if (tick) begin
                m_wrap  = (m_t == 5999);
                m_t     = (m_t + 1) % 6000;
                m_phase = 0;
            end else if (m_run) begin
                m_phase++;
            end
            if (ss) m_run = !m_run;
        end
    endtask

    task automatic step(bit ss, bit cl, bit lp);
        sw_if.start_stop = ss;
        sw_if.clear      = cl;
        sw_if.lap        = lp;
        @(posedge clk);
        model_step(ss, cl, lp);
        #1;
        sw_if.start_stop = 1'b0;
        sw_if.clear      = 1'b0;
        sw_if.lap        = 1'b0;
    endtask

    initial begin
        sw_if.start_stop = 1'b0;
        sw_if.clear      = 1'b0;
        sw_if.lap        = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("reset", dut_vec(), const_vec(0, 0, 0, 0));

        //            ss cl lp idle  t  run frz
        vecs[0]  = '{1, 0, 0, 0,  0, 1, 0};
        vecs[1]  = '{0, 0, 0, 2,  0, 1, 0};
        vecs[2]  = '{0, 0, 0, 0,  1, 1, 0};
        vecs[3]  = '{0, 0, 0, 35, 10, 1, 0};
        vecs[4]  = '{1, 0, 0, 9,  10, 0, 0};
        vecs[5]  = '{1, 0, 0, 1,  10, 1, 0};
        vecs[6]  = '{0, 0, 0, 0,  10, 1, 0};
        vecs[7]  = '{0, 0, 0, 0,  11, 1, 0};
        vecs[8]  = '{1, 1, 0, 0,  0, 0, 0};
        vecs[9]  = '{0, 0, 1, 0,  0, 0, 0};
        vecs[10] = '{1, 0, 0, 11, 2, 1, 0};
        vecs[11] = '{0, 0, 1, 0,  LAP_EN ? 2 : 3, 1, LAP_EN};
        vecs[12] = '{0, 0, 0, 7,  LAP_EN ? 2 : 5, 1, LAP_EN};
        vecs[13] = '{0, 0, 1, 0,  5, 1, 0};
        vecs[14] = '{0, 1, 0, 0,  0, 0, 0};

        for (int v = 0; v < 15; v++) begin
            step(vecs[v].ss, vecs[v].cl, vecs[v].lp);
            for (int k = 0; k < vecs[v].idle; k++) step(1'b0, 1'b0, 1'b0);
            check($sformatf("vec%0d", v), dut_vec(),
                  const_vec(vecs[v].exp_t, vecs[v].exp_run, vecs[v].exp_frz, 1'b0));
        end

        // Long run through the minute carry and the full wrap.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5000 && m_t != 599; i++) step(1'b0, 1'b0, 1'b0);
        check("at_0:59.9", dut_vec(), const_vec(599, 1, 0, 0));
        for (int i = 0; i < 10 && m_t != 600; i++) step(1'b0, 1'b0, 1'b0);
        check("at_1:00.0", dut_vec(), const_vec(600, 1, 0, 0));
        for (int i = 0; i < 30000 && m_t != 5999; i++) step(1'b0, 1'b0, 1'b0);
        check("at_9:59.9", dut_vec(), const_vec(5999, 1, 0, 0));
        for (int i = 0; i < 10 && m_t != 0; i++) step(1'b0, 1'b0, 1'b0);
        check("wrap_pulse", dut_vec(), const_vec(0, 1, 0, 1));
        step(1'b0, 1'b0, 1'b0);
        check("wrap_one_cycle", dut_vec(), const_vec(0, 1, 0, 0));

        // Randomized control pulses against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 19) == 0);
            check("random", dut_vec(), model_vec());
        end

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_midrun", dut_vec(), const_vec(0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
